vpu_operand_fetch: RTL

VPU_OPERAND_FETCH -- requirements
Module: vpu_operand_fetch

---
 rtl/vpu_operand_fetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/vpu_operand_fetch.sv
// Operand fetch engine: issues two back-to-back SRAM reads per enabled source
// port and collects the returned beats into small per-source operand queues.
module vpu_operand_fetch #(
  parameter int unsigned SRC_CNT = 3,
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        opget_start_i,
  input  logic [SRC_CNT-1:0]          src_en_i,
  input  logic [SRC_CNT*ADDR_W-1:0]   src_addr_i,
  output logic [SRC_CNT-1:0]          sram_rden_o,
  output logic [SRC_CNT*ADDR_W-1:0]   sram_raddr_o,
  input  logic [SRC_CNT*DATA_W-1:0]   sram_rdata_i,
  output logic                        opget_done_o,
  input  logic [SRC_CNT-1:0]          operand_queue_rden_i,
  output logic [SRC_CNT*DATA_W-1:0]   operand_data_o,
  output logic [SRC_CNT-1:0]          operand_valid_o,
  output logic                        busy_o,
  output logic                        underflow_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ0,
    S_REQ1,
    S_WAIT,
    S_DONE
  } state_t;

  state_t                      state;
  logic [SRC_CNT-1:0]          en_q;
  logic [SRC_CNT*ADDR_W-1:0]   addr_q;

  logic [DATA_W-1:0]           q_mem [SRC_CNT][2];
  logic [SRC_CNT-1:0]          wptr;
  logic [SRC_CNT-1:0]          rptr;
  logic [1:0]                  cnt [SRC_CNT];

  logic                        flush;
  logic                        wr_phase;
  logic [SRC_CNT-1:0]          q_wr;
  logic [SRC_CNT-1:0]          q_pop;
  logic [SRC_CNT-1:0]          q_empty;

  // Queue control decode: flush on accepted start, writes one cycle after each read
  always_comb begin
    flush    = (state == S_IDLE) && opget_start_i;
    wr_phase = (state == S_REQ1) || (state == S_WAIT);
    q_wr     = '0;
    q_pop    = '0;
    q_empty  = '0;
    for (int unsigned i = 0; i < SRC_CNT; i++) begin
      q_empty[i] = (cnt[i] == 2'd0);
      q_wr[i]    = wr_phase && en_q[i];
      q_pop[i]   = operand_queue_rden_i[i] && !q_empty[i];
    end
  end

  // Fetch sequencer; SRAM controls and done/busy are registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      en_q         <= '0;
      addr_q       <= '0;
      sram_rden_o  <= '0;
      sram_raddr_o <= '0;
      opget_done_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (opget_start_i) begin
            en_q         <= src_en_i;
            addr_q       <= src_addr_i;
            sram_rden_o  <= src_en_i;
            sram_raddr_o <= src_addr_i;
            busy_o       <= 1'b1;
            state        <= S_REQ0;
          end
        end
        S_REQ0: begin
          sram_rden_o <= en_q;
          for (int unsigned i = 0; i < SRC_CNT; i++) begin
            sram_raddr_o[i*ADDR_W +: ADDR_W] <= addr_q[i*ADDR_W +: ADDR_W] + ADDR_W'(1);
          end
          state <= S_REQ1;
        end
        S_REQ1: begin
          sram_rden_o  <= '0;
          sram_raddr_o <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          opget_done_o <= 1'b1;
          state        <= S_DONE;
        end
        S_DONE: begin
          opget_done_o <= 1'b0;
          busy_o       <= 1'b0;
          state        <= S_IDLE;
        end
        default: begin
          sram_rden_o  <= '0;
          sram_raddr_o <= '0;
          opget_done_o <= 1'b0;
          busy_o       <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

  // Per-source 2-entry operand queues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < SRC_CNT; i++) begin
        cnt[i]      <= 2'd0;
        q_mem[i][0] <= '0;
        q_mem[i][1] <= '0;
      end
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < SRC_CNT; i++) begin
        cnt[i] <= 2'd0;
      end
    end else begin
      for (int unsigned i = 0; i < SRC_CNT; i++) begin
        if (q_wr[i]) begin
          q_mem[i][wptr[i]] <= sram_rdata_i[i*DATA_W +: DATA_W];
          wptr[i]           <= ~wptr[i];
        end
        if (q_pop[i]) begin
          rptr[i] <= ~rptr[i];
        end
        case ({q_wr[i], q_pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 2'd1;
          2'b01:   cnt[i] <= cnt[i] - 2'd1;
          default: cnt[i] <= cnt[i];
        endcase
      end
    end
  end

  // Sticky underflow: any pop presented to an empty queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow_o <= 1'b0;
    end else if (|(operand_queue_rden_i & q_empty)) begin
      underflow_o <= 1'b1;
    end
  end

  // Queue heads and occupancy presented combinationally
  always_comb begin
    operand_data_o  = '0;
    operand_valid_o = '0;
    for (int unsigned i = 0; i < SRC_CNT; i++) begin
      operand_data_o[i*DATA_W +: DATA_W] = q_mem[i][rptr[i]];
      operand_valid_o[i]                 = !q_empty[i];
    end
  end

endmodule
